// File: rtl/sd_gather.sv
// sd_gather: collects one result word per masked lane after a control token and emits them as one item.
// Optional build macro SD_GATHER_TIMEOUT_EN closes an incomplete collection after `timeout` COLLECT cycles.
module sd_gather #(
    parameter int inputs  = 2,
    parameter int width   = 32,
    parameter int timeout = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      m_srdy,
    output logic                      m_drdy,
    input  logic [inputs-1:0]         m_mask,
    input  logic [inputs-1:0]         c_srdy,
    output logic [inputs-1:0]         c_drdy,
    input  logic [inputs*width-1:0]   c_data,
    output logic                      p_srdy,
    input  logic                      p_drdy,
    output logic [inputs*width-1:0]   p_data,
    output logic [inputs-1:0]         p_vld,
    output logic                      p_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        OUTPUT  = 2'd2
    } state_t;

    // Elaboration-time guards on the configuration.
    if (inputs < 1) begin : g_bad_inputs
        $error("sd_gather: inputs must be at least 1");
    end
    if (timeout < 2) begin : g_bad_timeout
        $error("sd_gather: timeout must be at least 2");
    end

    state_t                    state_q;
    logic [inputs-1:0]         mask_q;
    logic [inputs-1:0]         got_q;
    logic [inputs*width-1:0]   p_data_q;
    logic [inputs*width-1:0]   p_data_d;
    logic [inputs-1:0]         p_vld_q;
    logic                      p_srdy_q;

    logic [inputs-1:0]         xfer;
    logic [inputs-1:0]         got_all;
    logic                      done;
    logic                      timed_out;

    assign m_drdy  = (state_q == IDLE);
    // Ready per lane depends only on state, never on c_srdy, so upstream can wait on it.
    assign c_drdy  = (state_q == COLLECT) ? (mask_q & ~got_q) : '0;
    assign xfer    = c_srdy & c_drdy;
    assign got_all = got_q | xfer;
    assign done    = (got_all == mask_q);

    assign p_srdy  = p_srdy_q;
    assign p_data  = p_data_q;
    assign p_vld   = p_vld_q;

    always_comb begin
        p_data_d = p_data_q;
        if (state_q == IDLE && m_srdy) begin
            p_data_d = '0;
        end else if (state_q == COLLECT) begin
            for (int i = 0; i < inputs; i++) begin
                if (xfer[i]) begin
                    p_data_d[i*width +: width] = c_data[i*width +: width];
                end
            end
        end
    end

`ifdef SD_GATHER_TIMEOUT_EN
    localparam int CW = $clog2(timeout) + 1;

    logic [CW-1:0] cnt_q;
    logic          p_err_q;

    // Completion wins over expiry when both land in the same cycle.
    assign timed_out = (cnt_q == CW'(timeout - 1)) && !done;
    assign p_err     = p_err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (state_q == COLLECT) begin
            cnt_q <= cnt_q + CW'(1);
        end else begin
            cnt_q <= '0;
        end
    end
`else
    assign timed_out = 1'b0;
    assign p_err     = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            mask_q   <= '0;
            got_q    <= '0;
            p_srdy_q <= 1'b0;
            p_vld_q  <= '0;
            p_data_q <= '0;
`ifdef SD_GATHER_TIMEOUT_EN
            p_err_q  <= 1'b0;
`endif
        end else begin
            p_data_q <= p_data_d;
            case (state_q)
                IDLE: begin
                    if (m_srdy) begin
                        // An all-zero mask is shorthand for every lane.
                        mask_q  <= (m_mask == '0) ? '1 : m_mask;
                        got_q   <= '0;
                        state_q <= COLLECT;
                    end
                end
                COLLECT: begin
                    got_q <= got_all;
                    if (done) begin
                        state_q  <= OUTPUT;
                        p_srdy_q <= 1'b1;
                        p_vld_q  <= mask_q;
`ifdef SD_GATHER_TIMEOUT_EN
                        p_err_q  <= 1'b0;
`endif
                    end else if (timed_out) begin
                        state_q  <= OUTPUT;
                        p_srdy_q <= 1'b1;
                        p_vld_q  <= got_all;
`ifdef SD_GATHER_TIMEOUT_EN
                        p_err_q  <= 1'b1;
`endif
                    end
                end
                OUTPUT: begin
                    if (p_drdy) begin
                        state_q  <= IDLE;
                        p_srdy_q <= 1'b0;
                        p_vld_q  <= '0;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    p_srdy_q <= 1'b0;
                    p_vld_q  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_gather.sv
// Randomised self-checking bench for sd_gather; lane arrivals are scheduled per transaction and
// the expected item is built from the mask and the scheduled words.
module tb_sd_gather;
    localparam int N = 2;
    localparam int W = 32;
`ifdef SD_GATHER_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif

    logic             clk;
    logic             reset;
    logic             m_srdy;
    logic             m_drdy;
    logic [N-1:0]     m_mask;
    logic [N-1:0]     c_srdy;
    logic [N-1:0]     c_drdy;
    logic [N*W-1:0]   c_data;
    logic             p_srdy;
    logic             p_drdy;
    logic [N*W-1:0]   p_data;
    logic [N-1:0]     p_vld;
    logic             p_err;

    int checks   = 0;
    int failures = 0;

    sd_gather #(.inputs(N), .width(W), .timeout(TO)) dut (
        .clk    (clk),
        .reset  (reset),
        .m_srdy (m_srdy),
        .m_drdy (m_drdy),
        .m_mask (m_mask),
        .c_srdy (c_srdy),
        .c_drdy (c_drdy),
        .c_data (c_data),
        .p_srdy (p_srdy),
        .p_drdy (p_drdy),
        .p_data (p_data),
        .p_vld  (p_vld),
        .p_err  (p_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [N*W-1:0] rand_data();
        logic [N*W-1:0] d;
        for (int i = 0; i < N; i++) d[i*W +: W] = $urandom;
        return d;
    endfunction

    // One complete transaction; entered just after a falling edge with the DUT idle.
    task automatic run_txn(input logic [N-1:0] mask, input int d0, input int d1,
                           input logic [N*W-1:0] dat, input int stall, input string name);
        logic [N-1:0]   emask;
        logic [N-1:0]   sent;
        logic [N*W-1:0] exp_data;
        int             dly [N];
        int             cyc;
        emask  = (mask == '0) ? '1 : mask;
        dly[0] = d0;
        dly[1] = d1;
        exp_data = '0;
        for (int i = 0; i < N; i++)
            if (emask[i]) exp_data[i*W +: W] = dat[i*W +: W];

        // Token cycle: lane data is presented too but must not be taken yet.
        m_srdy = 1'b1;
        m_mask = mask;
        c_srdy = '1;
        c_data = ~dat;
        p_drdy = 1'($urandom_range(0, 1));
        #1;
        checks++;
        if (m_drdy !== 1'b1) begin failures++; $display("FAIL %s tok_m_drdy got=%0b exp=1", name, m_drdy); end
        checks++;
        if (c_drdy !== '0) begin failures++; $display("FAIL %s tok_c_drdy got=%b exp=00", name, c_drdy); end
        @(posedge clk);
        @(negedge clk);
        m_srdy = 1'b0;
        m_mask = N'($urandom);
        sent   = '0;
        cyc    = 0;
        while (1) begin
            for (int i = 0; i < N; i++) begin
                if (emask[i]) begin
                    c_srdy[i] = (!sent[i] && cyc >= dly[i]);
                    c_data[i*W +: W] = c_srdy[i] ? dat[i*W +: W] : W'($urandom);
                end else begin
                    c_srdy[i] = 1'b1;
                    c_data[i*W +: W] = W'($urandom);
                end
            end
            #1;
            if (sent == emask) begin
                p_drdy = 1'b0;
                checks++;
                if (p_srdy !== 1'b1) begin failures++; $display("FAIL %s out_p_srdy got=%0b exp=1 cyc=%0d", name, p_srdy, cyc); end
                break;
            end
            p_drdy = 1'($urandom_range(0, 1));
            checks++;
            if (p_srdy !== 1'b0) begin failures++; $display("FAIL %s early_p_srdy got=%0b exp=0 cyc=%0d", name, p_srdy, cyc); end
            checks++;
            if (c_drdy !== (emask & ~sent)) begin
                failures++;
                $display("FAIL %s col_c_drdy got=%b exp=%b cyc=%0d", name, c_drdy, emask & ~sent, cyc);
            end
            sent = sent | (c_srdy & emask & ~sent);
            if (cyc > 150) begin
                failures++;
                $display("FAIL %s collect_bound got=sent_%b exp=%b", name, sent, emask);
                break;
            end
            @(negedge clk);
            cyc++;
        end

        checks++;
        if (p_vld !== emask) begin failures++; $display("FAIL %s p_vld got=%b exp=%b", name, p_vld, emask); end
        checks++;
        if (p_data !== exp_data) begin failures++; $display("FAIL %s p_data got=%h exp=%h", name, p_data, exp_data); end
        checks++;
        if (p_err !== 1'b0) begin failures++; $display("FAIL %s p_err got=%0b exp=0", name, p_err); end
        checks++;
        if (m_drdy !== 1'b0 || c_drdy !== '0) begin
            failures++;
            $display("FAIL %s out_ready got=m%0b_c%b exp=m0_c00", name, m_drdy, c_drdy);
        end

        // Stall the output while a new token and lane data wait upstream.
        for (int s = 0; s < stall; s++) begin
            m_srdy = 1'b1;
            m_mask = N'($urandom);
            c_srdy = '1;
            c_data = rand_data();
            @(negedge clk);
            #1;
            checks++;
            if (p_srdy !== 1'b1 || p_data !== exp_data || p_vld !== emask) begin
                failures++;
                $display("FAIL %s stall_hold got=%0b/%h/%b exp=1/%h/%b", name, p_srdy, p_data, p_vld, exp_data, emask);
            end
            checks++;
            if (m_drdy !== 1'b0 || c_drdy !== '0) begin
                failures++;
                $display("FAIL %s stall_ready got=m%0b_c%b exp=m0_c00", name, m_drdy, c_drdy);
            end
        end
        p_drdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        p_drdy = 1'b0;
        m_srdy = 1'b0;
        c_srdy = '0;
        #1;
        checks++;
        if (p_srdy !== 1'b0 || p_vld !== '0 || m_drdy !== 1'b1) begin
            failures++;
            $display("FAIL %s release got=p%0b_v%b_m%0b exp=p0_v00_m1", name, p_srdy, p_vld, m_drdy);
        end
        $display("txn %s mask=%b vld=%b data=%h", name, mask, emask, exp_data);
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        m_srdy = 1'b0;
        m_mask = '0;
        c_srdy = '0;
        c_data = '0;
        p_drdy = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (p_srdy !== 1'b0 || p_vld !== '0 || p_err !== 1'b0 || p_data !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%0b/%b/%0b/%h exp=0/00/0/0", p_srdy, p_vld, p_err, p_data);
        end
        checks++;
        if (m_drdy !== 1'b1 || c_drdy !== '0) begin
            failures++;
            $display("FAIL reset_ready got=m%0b_c%b exp=m1_c00", m_drdy, c_drdy);
        end
        @(negedge clk);
        reset = 1'b0;
        $display("txn reset done");
    endtask

    task automatic test_directed();
        logic [N*W-1:0] d;
        d = {32'h0000BBBB, 32'h0000AAAA};
        run_txn(2'b11, 4, 2, d, 0, "split_arrival");
        run_txn(2'b00, 1, 1, rand_data(), 0, "all_lanes_same_cycle");
        run_txn(2'b10, 0, 0, rand_data(), 0, "lane1_only");
        run_txn(2'b01, 0, 3, rand_data(), 10, "output_stall");
    endtask

    task automatic test_reset_mid();
        m_srdy = 1'b1;
        m_mask = 2'b11;
        @(posedge clk);
        @(negedge clk);
        m_srdy = 1'b0;
        c_srdy = 2'b01;
        c_data = {32'h0, 32'h12345678};
        @(posedge clk);
        @(negedge clk);
        c_srdy = 2'b00;
        reset  = 1'b1;
        #1;
        checks++;
        if (p_srdy !== 1'b0 || p_data !== '0 || m_drdy !== 1'b1 || c_drdy !== '0) begin
            failures++;
            $display("FAIL reset_mid_async got=p%0b_d%h_m%0b_c%b exp=p0_d0_m1_c00", p_srdy, p_data, m_drdy, c_drdy);
        end
        @(negedge clk);
        reset  = 1'b0;
        c_srdy = 2'b11;
        c_data = rand_data();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            checks++;
            if (p_srdy !== 1'b0 || c_drdy !== '0 || m_drdy !== 1'b1) begin
                failures++;
                $display("FAIL reset_mid_idle got=p%0b_c%b_m%0b exp=p0_c00_m1", p_srdy, c_drdy, m_drdy);
            end
        end
        c_srdy = '0;
        run_txn(2'b10, 0, 1, rand_data(), 0, "after_reset");
    endtask

`ifdef SD_GATHER_TIMEOUT_EN
    task automatic test_timeout();
        logic [31:0] w0;
        w0 = $urandom;
        m_srdy = 1'b1;
        m_mask = 2'b11;
        @(posedge clk);
        @(negedge clk);
        m_srdy = 1'b0;
        for (int cyc = 0; cyc <= TO; cyc++) begin
            c_srdy = (cyc == 0) ? 2'b01 : 2'b00;
            c_data = {32'hFFFFFFFF, w0};
            #1;
            checks++;
            if (p_srdy !== (cyc == TO)) begin
                failures++;
                $display("FAIL timeout_p_srdy got=%0b exp=%0b cyc=%0d", p_srdy, cyc == TO, cyc);
            end
            if (cyc < TO) @(negedge clk);
        end
        checks++;
        if (p_vld !== 2'b01 || p_err !== 1'b1 || p_data !== {32'h0, w0}) begin
            failures++;
            $display("FAIL timeout_item got=v%b_e%0b_d%h exp=v01_e1_d%h", p_vld, p_err, p_data, {32'h0, w0});
        end
        p_drdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        p_drdy = 1'b0;
        c_srdy = '0;
        #1;
        checks++;
        if (p_srdy !== 1'b0 || m_drdy !== 1'b1) begin
            failures++;
            $display("FAIL timeout_release got=p%0b_m%0b exp=p0_m1", p_srdy, m_drdy);
        end
        $display("txn timeout vld=%b err=%0b", p_vld, p_err);
    endtask
`else
    task automatic test_no_timeout();
        run_txn(2'b11, 0, 60, rand_data(), 0, "long_wait");
    endtask
`endif

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            run_txn(N'($urandom), $urandom_range(0, 6), $urandom_range(0, 6),
                    rand_data(), $urandom_range(0, 3), "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid();
`ifdef SD_GATHER_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sd_gather.md
Name: sd_gather

Overview:
- Reassembly stage that sits directly downstream of the mirrored fork's parallel consumers.
- Takes one control token per transaction: a lane mask naming which downstream blocks received the mirrored item.
- Collects one result word from each named lane, in any order and at independent times.
- Presents the combined results as a single srdy/drdy output item carrying a lane-valid vector.

Parameters:
- inputs, 2, number of result lanes; must equal the fork's mirror count.
- width, 32, bits per lane result word.
- timeout, 1024, COLLECT cycle limit; used only with SD_GATHER_TIMEOUT_EN; must be ≥2.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- m_srdy  input  1  control token valid
- m_drdy  output  1  control token accepted
- m_mask  input  inputs  lanes to collect; all-zero means all lanes
- c_srdy  input  inputs  per-lane result valid
- c_drdy  output  inputs  per-lane result accepted
- c_data  input  inputs*width  lane i occupies bits [i*width +: width]
- p_srdy  output  1  gathered item valid (registered)
- p_drdy  input  1  downstream accept
- p_data  output  inputs*width  gathered results, same packing as c_data
- p_vld  output  inputs  lanes holding valid data in p_data
- p_err  output  1  item closed by timeout (constant 0 without macro)

Behaviour:
- Reset is asynchronous and active-high. State goes to IDLE, and mask, got, p_srdy, p_vld, p_err and the counter clear to 0. p_data clears to 0.
- Reset mid-operation discards any partial collection. No output is produced for it.
- Transfer rule: a transfer occurs on a cycle where srdy and drdy are both high at the clock edge.
- IDLE state:
  - m_drdy=1 combinationally. c_drdy=0. p_srdy=0.
  - On an m_srdy transfer, mask <= (m_mask==0 ? all ones : m_mask), got <= 0, and p_data lanes are zeroed. Next state is COLLECT.
- COLLECT state:
  - m_drdy=0.
  - c_drdy[i] = mask[i] & ~got[i], combinational and not dependent on c_srdy.
  - On a lane-i transfer, lane i of p_data <= c_data lane i and got[i] <= 1. Several lanes may transfer in the same cycle.
  - Lanes outside the mask never see c_drdy; their c_srdy is ignored.
  - When (got | this-cycle transfers) == mask, the next state is OUTPUT: p_srdy <= 1, p_vld <= mask, p_err <= 0.
  - Latency: p_srdy rises the cycle after the last lane's transfer.
- OUTPUT state:
  - p_srdy=1, m_drdy=0, c_drdy=0. p_data and p_vld are held stable.
  - On p_drdy, p_srdy <= 0, p_vld <= 0, and the next state is IDLE.
  - A new token can be accepted the cycle after the output transfer, giving one transaction per at least three cycles.
- p_drdy is ignored when p_srdy=0. Inputs arriving in IDLE or OUTPUT are stalled, not dropped.
- Data may not be accepted in the same cycle as its token; lanes are first accepted in the cycle after the token transfer.

Optional Feature:
- Macro: SD_GATHER_TIMEOUT_EN.
- With the macro:
  - A counter of width $clog2(timeout)+1 clears on COLLECT entry and increments each COLLECT cycle.
  - If the counter reaches timeout-1 and collection is still incomplete after that cycle's transfers, the next state is OUTPUT with p_vld <= got | transfers and p_err <= 1.
  - Missing lanes carry 0 in p_data.
  - Completion and timeout in the same cycle is treated as completion, with p_err=0.
- Without the macro: there is no counter, p_err is tied 0, and COLLECT waits indefinitely.

Test Plan:
- Token mask=2'b11. Lane1 sends 0xBBBB at cycle 3, lane0 sends 0xAAAA at cycle 5, p_drdy held 1 → p_srdy rises at cycle 6 with p_data={0xBBBB,0xAAAA}, p_vld=2'b11, p_err=0.
- Token mask=2'b00 (all lanes), both lanes valid on the same cycle → both captured in one cycle, p_srdy the next cycle, p_vld=2'b11.
- Token mask=2'b10, lane0 holds c_srdy=1 throughout → c_drdy[0] stays 0; output p_vld=2'b10, p_data lane0=0.
- Output stalled with p_drdy=0 for 10 cycles while a new token and lane data wait → m_drdy=0, c_drdy=0, p_data stable. After p_drdy=1, the token is taken the next cycle.
- Reset asserted mid-COLLECT with got=2'b01 → p_srdy=0, m_drdy=1 after release; lane0 data is not emitted.
- With SD_GATHER_TIMEOUT_EN and timeout=16, mask=2'b11, only lane0 arrives → after 16 COLLECT cycles, p_srdy=1, p_vld=2'b01, p_err=1.
